// File: rtl/button_repeat_counter_pkg.sv
// Shared definitions for the button auto-repeat counter: FSM encoding,
// default timing constants and a counter-width helper.
package button_repeat_counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    localparam int unsigned DEF_CLK_FREQ        = 30000000;
    localparam int unsigned DEF_DEBOUNCE_MS     = 10;
    localparam int unsigned DEF_REPEAT_DELAY_MS = 500;
    localparam int unsigned DEF_REPEAT_RATE_MS  = 100;
    localparam int unsigned COUNT_W             = 7;

    // Bits needed for a counter running 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_repeat_counter_if.sv
// Button/display signal bundle between the repeat counter and its user.
interface button_repeat_counter_if;
    import button_repeat_counter_pkg::*;

    logic               btn_n;
    logic [COUNT_W-1:0] count;
    logic               pressed;
    logic               step;

    modport master (output btn_n, input count, input pressed, input step);
    modport slave  (input btn_n, output count, output pressed, output step);

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus tick-based debouncer for one active-low button.
module button_debounce
    import button_repeat_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
    input  logic clk30,
    input  logic rst_n,
    input  logic btn_n,
    input  logic tick_ms,
    output logic pressed
);

    localparam int unsigned             STAB_W    = cnt_width(DEBOUNCE_MS);
    localparam logic [STAB_W-1:0]       STAB_LAST = STAB_W'(DEBOUNCE_MS - 1);

    logic              sync1_q;
    logic              sync2_q;
    logic              btn_s;
    logic [STAB_W-1:0] stab_cnt_q;
    logic [STAB_W-1:0] stab_cnt_d;
    logic              pressed_q;
    logic              pressed_d;

    // Synchronizer flops idle at the released level.
    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = ~sync2_q;

    // Any agreement between input and accepted level restarts the stability count.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        pressed_d  = pressed_q;
        if (btn_s == pressed_q) begin
            stab_cnt_d = '0;
        end else if (tick_ms) begin
            if (stab_cnt_q == STAB_LAST) begin
                stab_cnt_d = '0;
                pressed_d  = ~pressed_q;
            end else begin
                stab_cnt_d = stab_cnt_q + 1'b1;
            end
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
    end

    // Debouncer state register.
    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_q <= '0;
            pressed_q  <= 1'b0;
        end else begin
            stab_cnt_q <= stab_cnt_d;
            pressed_q  <= pressed_d;
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/button_repeat_counter.sv
// Debounced pushbutton driving a 7-bit step counter with delayed auto-repeat.
module button_repeat_counter
    import button_repeat_counter_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = DEF_CLK_FREQ,
    parameter int unsigned DEBOUNCE_MS     = DEF_DEBOUNCE_MS,
    parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
    input  logic                    clk30,
    input  logic                    rst_n,
    button_repeat_counter_if.slave  bus
);

    localparam int unsigned         PRESC_N    = CLK_FREQ / 1000;
    localparam int unsigned         PRESC_W    = cnt_width(PRESC_N);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESC_N - 1);
    localparam int unsigned         REP_MAX    = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                                 REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int unsigned         REP_W      = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0]    DELAY_LAST = REP_W'(REPEAT_DELAY_MS - 1);
    localparam logic [REP_W-1:0]    RATE_LAST  = REP_W'(REPEAT_RATE_MS - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick_ms;
    logic               tick_q;
    logic               pressed_s;
    rep_state_e         state_q;
    rep_state_e         state_d;
    logic [REP_W-1:0]   rep_cnt_q;
    logic [REP_W-1:0]   rep_cnt_d;
    logic               step_q;
    logic               step_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    assign tick_ms = (presc_q == PRESC_LAST);

    // Millisecond prescaler next value.
    always_comb begin
        presc_d = presc_q;
        if (tick_ms) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    button_debounce #(
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
        .clk30   (clk30),
        .rst_n   (rst_n),
        .btn_n   (bus.btn_n),
        .tick_ms (tick_ms),
        .pressed (pressed_s)
    );

    // The repeat timer uses a one-cycle-late tick so that a release accepted on
    // the same tick is already visible when the timer expires: release wins.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        step_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d   = DELAY;
                    rep_cnt_d = '0;
                    step_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DELAY: begin
                if (!pressed_s) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (tick_q) begin
                    if (rep_cnt_q == DELAY_LAST) begin
                        state_d   = REPEAT;
                        rep_cnt_d = '0;
                        step_d    = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = DELAY;
                end
            end
            REPEAT: begin
                if (!pressed_s) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (tick_q) begin
                    if (rep_cnt_q == RATE_LAST) begin
                        rep_cnt_d = '0;
                        step_d    = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = REPEAT;
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
    end

    // Display counter wraps freely modulo 128.
    always_comb begin
        count_d = count_q;
        if (step_q) begin
            count_d = count_q + COUNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State, timer and output registers.
    always_ff @(posedge clk30 or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            rep_cnt_q <= '0;
            step_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_ms;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            step_q    <= step_d;
            count_q   <= count_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.pressed = pressed_s;
    assign bus.step    = step_q;

endmodule

// File: tb/tb_button_repeat_counter.sv
// Directed bench for button_repeat_counter with a 10-cycle millisecond tick.
module tb_button_repeat_counter;
    import button_repeat_counter_pkg::*;

    typedef struct {
        int hold;
        int exp_steps;
        int exp_count;
    } vec_t;

    logic clk30 = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_total = 0;
    vec_t vecs[8];

    button_repeat_counter_if bus_if ();

    button_repeat_counter #(
        .CLK_FREQ        (10000),
        .DEBOUNCE_MS     (3),
        .REPEAT_DELAY_MS (20),
        .REPEAT_RATE_MS  (5)
    ) dut (
        .clk30 (clk30),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk30 = ~clk30;

    always @(negedge clk30) begin
        if (bus_if.step === 1'b1) step_total <= step_total + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk30);
        bus_if.btn_n = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk30);
        rst_n = 1'b1;
        repeat (2) @(negedge clk30);
    endtask

    // Press, hold for 'hold' cycles after acceptance, release; release falls 28 cycles later.
    task automatic run_press(input string tag, input int hold, input int exp_steps,
                             input int exp_count);
        int base;
        int n;
        base = step_total;
        @(negedge clk30);
        bus_if.btn_n = 1'b0;
        n = 0;
        while (bus_if.pressed !== 1'b1 && n < 80) begin
            @(negedge clk30);
            n++;
        end
        check({tag, "_accept"}, int'(bus_if.pressed), 1);
        @(negedge clk30);
        check({tag, "_first_step"}, int'(bus_if.step), 1);
        repeat (hold - 1) @(negedge clk30);
        bus_if.btn_n = 1'b1;
        n = 0;
        while (bus_if.pressed !== 1'b0 && n < 200) begin
            @(negedge clk30);
            n++;
        end
        check({tag, "_release_lat"}, n, 28);
        repeat (4) @(negedge clk30);
        check({tag, "_steps"}, step_total - base, exp_steps);
        check({tag, "_count"}, int'(bus_if.count), exp_count);
    endtask

    initial begin
        int  n;
        int  base;
        bit  seen;

        // hold = 10*m - 28 puts the debounced release on tick m after acceptance
        vecs[0] = '{hold:    2, exp_steps:  1, exp_count:  1};  // m=3
        vecs[1] = '{hold:  172, exp_steps:  1, exp_count:  2};  // m=20, ties first repeat
        vecs[2] = '{hold:  182, exp_steps:  2, exp_count:  4};  // m=21
        vecs[3] = '{hold:  272, exp_steps:  3, exp_count:  7};  // m=30, ties repeat
        vecs[4] = '{hold:  282, exp_steps:  4, exp_count: 11};  // m=31
        vecs[5] = '{hold: 1002, exp_steps: 18, exp_count: 29};  // m=103, clean hold
        vecs[6] = '{hold: 1022, exp_steps: 18, exp_count: 47};  // m=105, ties repeat
        vecs[7] = '{hold: 1032, exp_steps: 19, exp_count: 66};  // m=106

        bus_if.btn_n = 1'b1;
        do_reset();
        check("reset_count", int'(bus_if.count), 0);
        check("reset_pressed", int'(bus_if.pressed), 0);
        check("reset_step", int'(bus_if.step), 0);
        check("reset_state", int'(dut.state_q), int'(IDLE));

        // Glitch: two ticks low is one short of acceptance
        base = step_total;
        seen = 1'b0;
        @(negedge clk30);
        bus_if.btn_n = 1'b0;
        repeat (20) @(negedge clk30);
        bus_if.btn_n = 1'b1;
        repeat (60) begin
            @(negedge clk30);
            if (bus_if.pressed === 1'b1) seen = 1'b1;
        end
        check("glitch_pressed", int'(seen), 0);
        check("glitch_steps", step_total - base, 0);
        check("glitch_count", int'(bus_if.count), 0);

        // Bounce: toggle every 7 cycles, then settle low
        base = step_total;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk30);
            bus_if.btn_n = ((i / 7) % 2 == 0) ? 1'b0 : 1'b1;
            if (bus_if.pressed === 1'b1) seen = 1'b1;
        end
        @(negedge clk30);
        bus_if.btn_n = 1'b0;
        n = 0;
        while (bus_if.pressed !== 1'b1 && n < 80) begin
            @(negedge clk30);
            n++;
        end
        check("bounce_no_early", int'(seen), 0);
        check("bounce_not_before_3_ticks", int'(n >= 23), 1);
        check("bounce_within_3_ticks", int'(n <= 32), 1);
        @(negedge clk30);
        check("bounce_step", int'(bus_if.step), 1);
        bus_if.btn_n = 1'b1;
        repeat (60) @(negedge clk30);
        check("bounce_steps", step_total - base, 1);
        check("bounce_count", int'(bus_if.count), 1);

        // Hold-length table
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_press($sformatf("vec%0d", i), vecs[i].hold, vecs[i].exp_steps, vecs[i].exp_count);
        end

        // Wrap: 128 single presses
        do_reset();
        for (int i = 0; i < 128; i++) begin
            run_press($sformatf("wrap%0d", i), 2, 1, (i + 1) % 128);
        end

        // Reset mid-repeat with the button still held
        do_reset();
        @(negedge clk30);
        bus_if.btn_n = 1'b0;
        n = 0;
        while (bus_if.count !== 7'd9 && n < 3000) begin
            @(negedge clk30);
            n++;
        end
        check("midrep_reach9", int'(bus_if.count), 9);
        check("midrep_state_repeat", int'(dut.state_q), int'(REPEAT));
        rst_n = 1'b0;
        #1;
        check("midrep_rst_count", int'(bus_if.count), 0);
        check("midrep_rst_step", int'(bus_if.step), 0);
        check("midrep_rst_pressed", int'(bus_if.pressed), 0);
        check("midrep_rst_state", int'(dut.state_q), int'(IDLE));
        repeat (3) @(negedge clk30);
        rst_n = 1'b1;
        repeat (25) @(negedge clk30);
        check("midrep_n25_count", int'(bus_if.count), 0);
        repeat (4) @(negedge clk30);
        check("midrep_n29_pressed", int'(bus_if.pressed), 0);
        @(negedge clk30);
        check("midrep_n30_pressed", int'(bus_if.pressed), 1);
        @(negedge clk30);
        check("midrep_n31_step", int'(bus_if.step), 1);
        repeat (9) @(negedge clk30);
        check("midrep_n40_count", int'(bus_if.count), 1);
        bus_if.btn_n = 1'b1;
        repeat (40) @(negedge clk30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_repeat_counter.md
BUTTON_REPEAT_COUNTER -- requirements
Module: button_repeat_counter

Interface
REQ-001 Parameter CLK_FREQ, 30000000, clk30 frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, 10, number of consecutive 1 ms ticks a new level must hold before it is accepted.
REQ-003 Parameter REPEAT_DELAY_MS, 500, hold time from accepted press to the first auto-repeat step.
REQ-004 Parameter REPEAT_RATE_MS, 100, period between later auto-repeat steps.
REQ-005 clk30  input  1  single system clock; all logic on posedge clk30.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 btn_n  input  1  raw pushbutton, asynchronous to clk30, 0 = pressed.
REQ-008 count  output 7  step counter for direct LED display.
REQ-009 pressed  output 1  debounced button level, 1 = pressed.
REQ-010 step  output 1  one-cycle pulse per counted step.

Function
REQ-011 btn_n SHALL pass through a 2-flop synchronizer and then be inverted to give the internal signal btn_s (1 = pressed).
REQ-012 Prescaler SHALL count 0..CLK_FREQ/1000-1, wrap, and assert tick_ms for one cycle at wrap; it free-runs outside reset.
REQ-013 Debouncer: any cycle with btn_s == pressed SHALL clear stab_cnt. On tick_ms with btn_s != pressed, stab_cnt increments. When stab_cnt == DEBOUNCE_MS-1 on such a tick, pressed SHALL toggle and stab_cnt SHALL clear.
REQ-014 FSM states: IDLE, DELAY, REPEAT. rep_cnt counts tick_ms in DELAY and REPEAT.
REQ-015 IDLE -> DELAY on the cycle after pressed rises. step SHALL assert in that same cycle and rep_cnt SHALL clear.
REQ-016 DELAY -> REPEAT when rep_cnt reaches REPEAT_DELAY_MS-1 on tick_ms. step SHALL assert in that cycle and rep_cnt SHALL clear.
REQ-017 REPEAT: when rep_cnt reaches REPEAT_RATE_MS-1 on tick_ms, step SHALL assert, rep_cnt SHALL clear, and the state SHALL stay REPEAT.
REQ-018 DELAY or REPEAT -> IDLE on the cycle after pressed falls; no step on release.
REQ-019 If the release transition and repeat-timer expiry fall in the same cycle, release SHALL win: go to IDLE, no step.
REQ-020 count SHALL increment by 1 in the cycle after each step. It wraps modulo 128 (127 -> 0) with no saturation and no flag.
REQ-021 Steps, and therefore count increments, SHALL NOT occur in any other cycle.

Reset
REQ-022 While rst_n = 0, the following SHALL be held immediately and asynchronously: synchronizer flops = 1 (released), prescaler = 0, stab_cnt = 0, pressed = 0, state = IDLE, rep_cnt = 0, step = 0, count = 0.
REQ-023 Reset asserted mid-hold SHALL abort the repeat sequence. After release of reset, a still-held button SHALL be re-debounced and then produce a fresh first step.
REQ-024 rst_n deassertion SHALL be used directly. The block adds no reset synchronizer; that is the integration owner's job.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (2-bit: IDLE = 0, DELAY = 1, REPEAT = 2) and the default timing constants.
REQ-026 The synchronizer and debouncer SHALL be one sub-module, button_debounce (ports: clk30, rst_n, btn_n, tick_ms, pressed). It is reused for the second button.
REQ-027 Counter widths SHALL be derived with $clog2 from the parameters. No width is hard-coded except count = 7.

Verification
Bench parameters: CLK_FREQ = 10000 (tick every 10 cycles), DEBOUNCE_MS = 3, REPEAT_DELAY_MS = 20, REPEAT_RATE_MS = 5.
REQ-028 Clean press, held 100 ticks, then released -> exactly one step at acceptance, first repeat 20 ticks later, then one step every 5 ticks. Result: count = 1 + 1 + 16 = 18; pressed falls 3 ticks after release.
REQ-029 Bounce: btn_n toggles every 7 cycles for 50 cycles, then stays low -> pressed rises only after 3 stable ticks, exactly one step, count = 1.
REQ-030 Glitch: btn_n low for 2 ticks, then high -> pressed never asserts, no step, count = 0.
REQ-031 Wrap: 128 separate clean presses -> count goes 127 -> 0 on the 128th.
REQ-032 Reset mid-REPEAT at count = 9 -> count = 0, state IDLE, step = 0 immediately. Button still held -> count = 1 after 3 ticks plus sync latency.
REQ-033 Release timed so debounced release and repeat expiry coincide -> no step in that cycle; state IDLE.
